// File: rtl/regs_pkg.sv
// Shared types and sizes for the register file and its write-port arbiter.
package regs_pkg;

    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;

    // Arbiter sequencing: CLEAR zeroes x1..x31 after reset, RUN serves requesters.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CLEAR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CLEAR_LAST  = ADDR_W'(REG_COUNT - 1);

endpackage

// File: rtl/registers.sv
// 32 x 32 register file: one write port, two combinational read ports, x0 hardwired to zero.
module registers
    import regs_pkg::*;
(
    input  logic              clk_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem [REG_COUNT];

    // Capture the write on the edge ending the grant cycle; x0 is never stored.
    always_ff @(posedge clk_i) begin
        if (write_i && (waddr_i != '0)) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read with x0 forced to zero.
    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : mem[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : mem[raddr2_i];
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Write-port arbiter for the register file.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | drive zero into x1..x31 one per cycle, requesters held off
//   ST_RUN   | fixed-priority writeback, debug wins after STARVE_LIMIT stalls
//
// Grants and port outputs are combinational from state, counter and requests
// so a requester sees ready in the same cycle it raises valid.
module register_write_arbiter
    import regs_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_waddr_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    output logic              wb_ready_o,
    input  logic              dbg_valid_i,
    input  logic [ADDR_W-1:0] dbg_waddr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ready_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              busy_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [3:0]        starve_q;
    logic              dbg_grant;
    logic              wb_grant;

    // Arbitration: debug wins when writeback is idle or debug has starved long enough.
    always_comb begin
        dbg_grant = 1'b0;
        wb_grant  = 1'b0;
        if (!rst_i && (state_q == ST_RUN)) begin
            dbg_grant = dbg_valid_i && ((starve_q == LIMIT) || !wb_valid_i);
            wb_grant  = wb_valid_i && !dbg_grant;
        end
    end

    // Port mux: clear sequencer, granted requester, or idle; x0 writes are accepted but suppressed.
    always_comb begin
        write_o     = 1'b0;
        waddr_o     = '0;
        wdata_o     = '0;
        wb_ready_o  = 1'b0;
        dbg_ready_o = 1'b0;
        busy_o      = 1'b1;
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                write_o = 1'b1;
                waddr_o = clr_addr_q;
            end else begin
                busy_o      = 1'b0;
                wb_ready_o  = wb_grant;
                dbg_ready_o = dbg_grant;
                if (dbg_grant) begin
                    write_o = (dbg_waddr_i != '0);
                    waddr_o = dbg_waddr_i;
                    wdata_o = dbg_wdata_i;
                end else if (wb_grant) begin
                    write_o = (wb_waddr_i != '0);
                    waddr_o = wb_waddr_i;
                    wdata_o = wb_wdata_i;
                end
            end
        end
    end

    // Sequencer state, clear address and debug starvation counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= CLEAR_FIRST;
            starve_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    if (clr_addr_q == CLEAR_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (dbg_grant || !dbg_valid_i) begin
                        starve_q <= '0;
                    end else if (starve_q != LIMIT) begin
                        starve_q <= starve_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter wired to the register file.
module tb_register_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_valid_i, dbg_valid_i;
    logic [4:0]  wb_waddr_i, dbg_waddr_i;
    logic [31:0] wb_wdata_i, dbg_wdata_i;
    logic        wb_ready_o, dbg_ready_o, write_o, busy_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;

    int errors = 0;
    int checks = 0;

    // reference model: register contents and how long debug has waited
    logic [31:0] mem_m [32];
    int          dbg_wait;
    logic        exp_wb, exp_dbg;

    typedef struct {
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        dv;
        logic [4:0]  da;
        logic [31:0] dd;
        logic        ewr;
        logic        edr;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [12];

    always #5 clk_i = ~clk_i;

    register_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wb_valid_i  (wb_valid_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .wb_ready_o  (wb_ready_o),
        .dbg_valid_i (dbg_valid_i),
        .dbg_waddr_i (dbg_waddr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_ready_o (dbg_ready_o),
        .write_o     (write_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .busy_o      (busy_o)
    );

    registers u_regs (
        .clk_i    (clk_i),
        .write_i  (write_o),
        .waddr_i  (waddr_o),
        .wdata_i  (wdata_o),
        .raddr1_i (raddr1),
        .rdata1_o (rdata1),
        .raddr2_i (raddr2),
        .rdata2_o (rdata2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic randomize_inputs();
        wb_valid_i  = 1'($urandom_range(0, 1));
        wb_waddr_i  = 5'($urandom_range(0, 31));
        wb_wdata_i  = $urandom;
        dbg_valid_i = 1'b1;
        dbg_waddr_i = 5'($urandom_range(0, 31));
        dbg_wdata_i = $urandom;
    endtask

    // hold reset high for n cycles and check the forced outputs
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            rst_i = 1'b1;
            randomize_inputs();
            #1;
            chk("rst_write", 32'(write_o), 32'd0);
            chk("rst_waddr", 32'(waddr_o), 32'd0);
            chk("rst_wdata", wdata_o, 32'd0);
            chk("rst_wb_ready", 32'(wb_ready_o), 32'd0);
            chk("rst_dbg_ready", 32'(dbg_ready_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd1);
            @(posedge clk_i);
        end
    endtask

    // clear cycles 1..last after reset release; requests are presented and must be ignored
    task automatic clear_seq(input int last);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk_i);
            rst_i = 1'b0;
            randomize_inputs();
            #1;
            chk("clr_busy", 32'(busy_o), 32'd1);
            chk("clr_write", 32'(write_o), 32'd1);
            chk("clr_waddr", 32'(waddr_o), 32'(k));
            chk("clr_wdata", wdata_o, 32'd0);
            chk("clr_wb_ready", 32'(wb_ready_o), 32'd0);
            chk("clr_dbg_ready", 32'(dbg_ready_o), 32'd0);
            @(posedge clk_i);
        end
        if (last == 31) begin
            for (int a = 0; a < 32; a++) mem_m[a] = 32'd0;
            dbg_wait = 0;
        end
    endtask

    // drive one RUN cycle and compare against the model (does not advance the clock edge)
    task automatic apply(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic dv, input logic [4:0] da, input logic [31:0] dd);
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        @(negedge clk_i);
        rst_i       = 1'b0;
        wb_valid_i  = wv;
        wb_waddr_i  = wa;
        wb_wdata_i  = wd;
        dbg_valid_i = dv;
        dbg_waddr_i = da;
        dbg_wdata_i = dd;
        #1;
        exp_dbg = dv && (dbg_wait >= LIMIT || !wv);
        exp_wb  = wv && !exp_dbg;
        ew = 1'b0;
        ea = 5'd0;
        ed = 32'd0;
        if (exp_dbg) begin
            ew = (da != 5'd0); ea = da; ed = dd;
        end else if (exp_wb) begin
            ew = (wa != 5'd0); ea = wa; ed = wd;
        end
        chk("busy", 32'(busy_o), 32'd0);
        chk("wb_ready", 32'(wb_ready_o), 32'(exp_wb));
        chk("dbg_ready", 32'(dbg_ready_o), 32'(exp_dbg));
        chk("write", 32'(write_o), 32'(ew));
        chk("waddr", 32'(waddr_o), 32'(ea));
        chk("wdata", wdata_o, ed);
        chk("rdata1", rdata1, mem_m[raddr1]);
        chk("rdata2", rdata2, mem_m[raddr2]);
    endtask

    // take the clock edge and advance the model
    task automatic tick();
        @(posedge clk_i);
        if (exp_dbg) begin
            if (dbg_waddr_i != 5'd0) mem_m[dbg_waddr_i] = dbg_wdata_i;
            dbg_wait = 0;
        end else begin
            if (exp_wb && wb_waddr_i != 5'd0) mem_m[wb_waddr_i] = wb_wdata_i;
            if (dbg_valid_i) dbg_wait = (dbg_wait + 1 > LIMIT) ? LIMIT : dbg_wait + 1;
            else             dbg_wait = 0;
        end
    endtask

    task automatic idle();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic        nwv, ndv;
        logic [4:0]  nwa, nda;
        logic [31:0] nwd, ndd;

        tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
        tbl[1]  = '{1'b1, 5'd7,  32'h11111111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd7,  32'h11111111};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h22222222, 1'b0, 1'b1, 1'b1, 5'd9,  32'h22222222};
        tbl[3]  = '{1'b1, 5'd10, 32'hA0A0A0A0, 1'b1, 5'd11, 32'hB1B1B1B1, 1'b1, 1'b0, 1'b1, 5'd10, 32'hA0A0A0A0};
        tbl[4]  = '{1'b1, 5'd0,  32'hC2C2C2C2, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'hC2C2C2C2};
        tbl[5]  = '{1'b1, 5'd12, 32'hD3D3D3D3, 1'b1, 5'd20, 32'hE4E4E4E4, 1'b1, 1'b0, 1'b1, 5'd12, 32'hD3D3D3D3};
        tbl[6]  = '{1'b1, 5'd13, 32'hD3D3D3D4, 1'b1, 5'd20, 32'hE4E4E4E4, 1'b1, 1'b0, 1'b1, 5'd13, 32'hD3D3D3D4};
        tbl[7]  = '{1'b1, 5'd14, 32'hD3D3D3D5, 1'b1, 5'd20, 32'hE4E4E4E4, 1'b1, 1'b0, 1'b1, 5'd14, 32'hD3D3D3D5};
        tbl[8]  = '{1'b1, 5'd15, 32'hD3D3D3D6, 1'b1, 5'd20, 32'hE4E4E4E4, 1'b1, 1'b0, 1'b1, 5'd15, 32'hD3D3D3D6};
        tbl[9]  = '{1'b1, 5'd16, 32'hF5F5F5F5, 1'b1, 5'd20, 32'hE4E4E4E4, 1'b0, 1'b1, 1'b1, 5'd20, 32'hE4E4E4E4};
        tbl[10] = '{1'b1, 5'd16, 32'hF5F5F5F5, 1'b1, 5'd21, 32'h06060606, 1'b1, 1'b0, 1'b1, 5'd16, 32'hF5F5F5F5};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0};

        rst_i = 1'b1;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        dbg_wait = 0;
        exp_wb = 1'b0;
        exp_dbg = 1'b0;
        randomize_inputs();

        // power-up reset and first clear sequence, then first RUN cycle
        do_reset(3);
        clear_seq(31);
        idle();

        // writeback with debug idle: ready same cycle, readable next cycle
        apply(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("wb_x3_ready", 32'(wb_ready_o), 32'd1);
        tick();
        raddr1 = 5'd3;
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("wb_x3_read", rdata1, 32'hDEADBEEF);
        tick();

        // table vectors
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].dv, tbl[i].da, tbl[i].dd);
            chk($sformatf("tbl%0d_wb_ready", i), 32'(wb_ready_o), 32'(tbl[i].ewr));
            chk($sformatf("tbl%0d_dbg_ready", i), 32'(dbg_ready_o), 32'(tbl[i].edr));
            chk($sformatf("tbl%0d_write", i), 32'(write_o), 32'(tbl[i].ew));
            chk($sformatf("tbl%0d_waddr", i), 32'(waddr_o), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d_wdata", i), wdata_o, tbl[i].ed);
            tick();
        end

        // continuous contention: debug on every (LIMIT+1)th cycle
        for (int i = 1; i <= 15; i++) begin
            apply(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b1, 5'd25, 32'h55AA55AA);
            chk($sformatf("starve%0d_dbg_ready", i), 32'(dbg_ready_o), 32'((i % (LIMIT + 1)) == 0));
            chk($sformatf("starve%0d_wb_ready", i), 32'(wb_ready_o), 32'((i % (LIMIT + 1)) != 0));
            tick();
        end
        idle();

        // debug write to x0: accepted, not written
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678);
        chk("dbg_x0_ready", 32'(dbg_ready_o), 32'd1);
        chk("dbg_x0_write", 32'(write_o), 32'd0);
        tick();
        raddr1 = 5'd0;
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("dbg_x0_read", rdata1, 32'd0);
        tick();

        // debug stalls twice, drops, re-asserts: counter restarts from zero
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 5'd4, 32'h4444, 1'b1, 5'd6, 32'h6666);
            tick();
        end
        apply(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'd0);
        tick();
        for (int i = 1; i <= LIMIT + 1; i++) begin
            apply(1'b1, 5'd4, 32'h4444, 1'b1, 5'd6, 32'h6666);
            chk($sformatf("drop%0d_dbg_ready", i), 32'(dbg_ready_o), 32'(i == LIMIT + 1));
            tick();
        end
        idle();

        // randomized traffic honouring the hold-until-ready handshake
        for (int i = 0; i < 400; i++) begin
            if (wb_valid_i && !exp_wb) begin
                nwv = ($urandom_range(0, 7) != 0);
                nwa = wb_waddr_i;
                nwd = wb_wdata_i;
            end else begin
                nwv = ($urandom_range(0, 3) != 0);
                nwa = 5'($urandom_range(0, 31));
                nwd = $urandom;
            end
            if (dbg_valid_i && !exp_dbg) begin
                ndv = ($urandom_range(0, 7) != 0);
                nda = dbg_waddr_i;
                ndd = dbg_wdata_i;
            end else begin
                ndv = ($urandom_range(0, 1) != 0);
                nda = 5'($urandom_range(0, 31));
                ndd = $urandom;
            end
            raddr1 = 5'($urandom_range(0, 31));
            raddr2 = 5'($urandom_range(0, 31));
            apply(nwv, nwa, nwd, ndv, nda, ndd);
            tick();
        end
        idle();

        // poison x5 and x31, then reset must wipe them
        apply(1'b1, 5'd5, 32'hBADC0DE5, 1'b0, 5'd0, 32'd0);
        tick();
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'hBADC0D31);
        tick();
        raddr1 = 5'd5;
        raddr2 = 5'd31;
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("poison_x5", rdata1, 32'hBADC0DE5);
        chk("poison_x31", rdata2, 32'hBADC0D31);
        tick();
        do_reset(1);
        clear_seq(31);
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("cleared_x5", rdata1, 32'd0);
        chk("cleared_x31", rdata2, 32'd0);
        tick();

        // reset pulse while clear address 17 is driven restarts the sequence
        do_reset(1);
        clear_seq(16);
        do_reset(1);
        clear_seq(31);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
